// File: rtl/medidor_frec_multi_pkg.sv
// medidor_pkg: shared state encoding, gate counter width and channel-index width helper
package medidor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        DRAIN
    } state_t;

    localparam int GATE_W = 32;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/medidor_frec_multi_detector_flanco.sv
// detector_flanco: two-flop synchroniser plus history flop, emits a one-cycle pulse per rising edge
module detector_flanco (
    input  logic clock,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q, hist_d;

    // shift the asynchronous input through the synchroniser into the history flop
    always_comb begin
        sync1_d = sig_in;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    // pipeline registers run in every FSM state
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    assign rise = sync2_q & ~hist_q;

endmodule

// File: rtl/medidor_frec_multi.sv
// medidor_frec_multi: counts rising edges on N_CH inputs over a 2^resol gate, then streams one result per channel
module medidor_frec_multi
    import medidor_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int OUT_WIDTH = 32,
    parameter int CH_W      = ch_width(N_CH)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [4:0]           resol,
    input  logic [N_CH-1:0]      sig_in,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_W-1:0]      out_ch,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 out_ovf
);

    state_t               state_q, state_d;
    logic [4:0]           resol_q, resol_d;
    logic [GATE_W-1:0]    gate_q, gate_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [OUT_WIDTH-1:0] cnt_q [N_CH];
    logic [OUT_WIDTH-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]      ovf_q, ovf_d;
    logic [N_CH-1:0]      rise;
    logic                 win_last, beat_last, open_win;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_det
            detector_flanco u_det (
                .clock   (clock),
                .reset_n (reset_n),
                .sig_in  (sig_in[g]),
                .rise    (rise[g])
            );
        end
    endgenerate

    // next-state logic: window timing, saturating edge counters and readout sequencing
    always_comb begin
        state_d   = state_q;
        resol_d   = resol_q;
        gate_d    = gate_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        open_win  = 1'b0;
        win_last  = gate_q == ((GATE_W'(1) << resol_q) - GATE_W'(1));
        beat_last = ch_q == CH_W'(N_CH - 1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = GATE;
                    open_win = 1'b1;
                end
            end
            GATE: begin
                gate_d = gate_q + GATE_W'(1);
                for (int c = 0; c < N_CH; c++) begin
                    if (rise[c]) begin
                        if (&cnt_q[c]) ovf_d[c] = 1'b1;
                        else cnt_d[c] = cnt_q[c] + OUT_WIDTH'(1);
                    end
                end
                if (win_last) begin
                    state_d = DRAIN;
                    ch_d    = '0;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (!beat_last) begin
                        ch_d = ch_q + CH_W'(1);
                    end else begin
                        ch_d     = '0;
                        state_d  = continuous ? GATE : IDLE;
                        open_win = continuous;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (open_win) begin
            resol_d = resol;
            gate_d  = '0;
            ovf_d   = '0;
            for (int c = 0; c < N_CH; c++) cnt_d[c] = '0;
        end
    end

    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            resol_q <= '0;
            gate_q  <= '0;
            ch_q    <= '0;
            cnt_q   <= '{default: '0};
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            resol_q <= resol_d;
            gate_q  <= gate_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign out_valid = state_q == DRAIN;
    assign out_ch    = ch_q;
    assign out       = cnt_q[ch_q];
    assign out_ovf   = ovf_q[ch_q];

endmodule

// File: tb/tb_medidor_frec_multi.sv
// tb_medidor_frec_multi: directed checks of window timing, counts, saturation, backpressure, continuous mode and reset
module tb_medidor_frec_multi;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic        continuous = 1'b0;
    logic        out_ready = 1'b1;
    logic [4:0]  resol = 5'd4;
    logic [3:0]  sig_in = 4'd0;
    logic        busy, out_valid, out_ovf;
    logic [1:0]  out_ch;
    logic [31:0] out;
    logic        busy_s, out_valid_s, out_ovf_s;
    logic [1:0]  out_ch_s;
    logic [3:0]  out_s;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          per [4] = '{0, 0, 0, 0};

    medidor_frec_multi #(.N_CH(4), .OUT_WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .continuous(continuous),
        .resol(resol), .sig_in(sig_in), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_ch(out_ch), .out(out), .out_ovf(out_ovf)
    );

    medidor_frec_multi #(.N_CH(4), .OUT_WIDTH(4)) dut_s (
        .clock(clock), .reset_n(reset_n), .start(start_s), .continuous(1'b0),
        .resol(resol), .sig_in(sig_in), .busy(busy_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_ch(out_ch_s), .out(out_s), .out_ovf(out_ovf_s)
    );

    always #5 clock = ~clock;

    // free-running cycle count used to shape the periodic test signals
    always @(posedge clock) cyc <= cyc + 1;

    // square waves of the requested period per channel, changed away from the sampling edge
    always @(negedge clock) begin
        for (int c = 0; c < 4; c++) sig_in[c] = (per[c] != 0) && ((cyc % per[c]) < per[c] / 2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
    endtask

    task automatic wait_window(input int n);
        repeat (n - 1) @(posedge clock);
        #1 chk("valid_before_end", 32'(out_valid), 0);
        @(posedge clock); #1;
        chk("valid_at_end", 32'(out_valid), 1);
    endtask

    task automatic drain(input int e [4], input logic [3:0] ov, input int stall);
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                chk("stall_ch", 32'(out_ch), 32'(i));
                chk("stall_out", out, 32'(e[i]));
                chk("stall_valid", 32'(out_valid), 1);
                @(posedge clock); #1;
            end
            out_ready = 1'b1;
            chk("beat_valid", 32'(out_valid), 1);
            chk("beat_ch", 32'(out_ch), 32'(i));
            chk("beat_out", out, 32'(e[i]));
            chk("beat_ovf", 32'(out_ovf), 32'(ov[i]));
            @(posedge clock); #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ch", 32'(out_ch), 0);
        chk("rst_out", out, 0);
        chk("rst_ovf", 32'(out_ovf), 0);
        reset_n = 1'b1;
        per = '{4, 8, 0, 2};
        repeat (6) @(posedge clock);
        #1;
        // basic window; resol changed after the start must not alter the window
        resol = 5'd4;
        do_start();
        resol = 5'd7;
        wait_window(16);
        drain('{4, 2, 0, 8}, 4'b0000, 0);
        chk("basic_idle", 32'(busy), 0);
        // backpressure: three stall cycles per beat
        resol = 5'd4;
        do_start();
        wait_window(16);
        drain('{4, 2, 0, 8}, 4'b0000, 3);
        chk("bp_idle", 32'(busy), 0);
        // saturation on the narrow instance
        per = '{2, 0, 0, 0};
        repeat (4) @(posedge clock);
        #1;
        resol = 5'd6;
        start_s = 1'b1;
        @(posedge clock); #1;
        start_s = 1'b0;
        chk("sat_busy", 32'(busy_s), 1);
        repeat (63) @(posedge clock);
        #1 chk("sat_valid_before", 32'(out_valid_s), 0);
        @(posedge clock); #1;
        chk("sat_valid", 32'(out_valid_s), 1);
        chk("sat_out0", 32'(out_s), 15);
        chk("sat_ovf0", 32'(out_ovf_s), 1);
        for (int i = 1; i < 4; i++) begin
            @(posedge clock); #1;
            chk("sat_ch", 32'(out_ch_s), 32'(i));
            chk("sat_outn", 32'(out_s), 0);
            chk("sat_ovfn", 32'(out_ovf_s), 0);
        end
        @(posedge clock); #1;
        chk("sat_idle", 32'(busy_s), 0);
        // continuous mode: three back-to-back windows
        per = '{4, 0, 0, 0};
        repeat (4) @(posedge clock);
        #1;
        resol = 5'd3;
        continuous = 1'b1;
        do_start();
        wait_window(8);
        drain('{2, 0, 0, 0}, 4'b0000, 0);
        chk("cont_busy1", 32'(busy), 1);
        wait_window(8);
        drain('{2, 0, 0, 0}, 4'b0000, 0);
        chk("cont_busy2", 32'(busy), 1);
        wait_window(8);
        continuous = 1'b0;
        drain('{2, 0, 0, 0}, 4'b0000, 0);
        chk("cont_idle", 32'(busy), 0);
        repeat (8) @(posedge clock);
        #1 chk("cont_no_valid", 32'(out_valid), 0);
        // reset mid-gate
        per = '{4, 8, 0, 2};
        resol = 5'd4;
        do_start();
        repeat (5) @(posedge clock);
        #1 reset_n = 1'b0;
        @(posedge clock); #1;
        chk("rg_busy", 32'(busy), 0);
        chk("rg_valid", 32'(out_valid), 0);
        chk("rg_out", out, 0);
        reset_n = 1'b1;
        // reset mid-drain
        do_start();
        wait_window(16);
        @(posedge clock); #1;
        chk("rd_ch_before", 32'(out_ch), 1);
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("rd_busy", 32'(busy), 0);
        chk("rd_valid", 32'(out_valid), 0);
        chk("rd_ch", 32'(out_ch), 0);
        chk("rd_out", out, 0);
        chk("rd_ovf", 32'(out_ovf), 0);
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        do_start();
        wait_window(16);
        drain('{4, 2, 0, 8}, 4'b0000, 0);
        // one-cycle window with start held high throughout
        per = '{4, 0, 0, 2};
        resol = 5'd0;
        do_start();
        start = 1'b1;
        wait_window(1);
        for (int i = 0; i < 4; i++) begin
            chk("r0_ch", 32'(out_ch), 32'(i));
            chk("r0_le1", 32'(out <= 32'd1), 1);
            @(posedge clock); #1;
        end
        chk("r0_idle", 32'(busy), 0);
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk("r0_no_extra_busy", 32'(busy), 0);
        chk("r0_no_extra_valid", 32'(out_valid), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/medidor_frec_multi.md
# medidor_frec_multi

Multi-channel, single-clock frequency meter: counts rising edges on `N_CH` asynchronous input signals over a common gate window of 2^resol reference cycles, then streams one result per channel over a valid/ready interface. It is the parametrised successor to our single-channel meter, used to characterise ring-oscillator banks in parallel. It adds single-shot and continuous modes, saturation with overflow flags, and backpressure-aware readout.

## Interface
- `N_CH`, 4: number of measured channels (≥1).
- `OUT_WIDTH`, 32: width of each edge counter and result (1..32).
- `CH_W`, derived: max(1, $clog2(N_CH)); width of `out_ch`.
- `clock`  in  1: reference clock; all logic on rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `start`  in  1: request one measurement; sampled only in IDLE.
- `continuous`  in  1: when high at the end of a readout, the next window starts with no new `start`.
- `resol`  in  5: gate exponent; window = 2^resol cycles; latched when a window begins.
- `sig_in`  in  N_CH: measured signals, asynchronous to `clock`.
- `busy`  out  1: high in any state other than IDLE.
- `out_valid`  out  1: result beat available.
- `out_ready`  in  1: consumer accepts beat when `out_valid & out_ready`.
- `out_ch`  out  CH_W: channel index of current beat.
- `out`  out  OUT_WIDTH: edge count for `out_ch`.
- `out_ovf`  out  1: count for `out_ch` saturated.

## Operation
- Per channel: 2-flop synchroniser, then one history flop. Rising edge = sync2 & ~hist. These flops run in every state.
- States:
  - IDLE: `start`=1 → GATE. Latch `resol`, clear gate counter, clear all edge counters and ovf bits.
  - GATE: each cycle, a detected edge increments that channel's counter. The window lasts exactly 2^resol cycles, with the counter compared against the latched value. On the last window cycle the edge is still counted, then → DRAIN with `out_ch`=0.
  - DRAIN: `out_valid`=1. On handshake: if `out_ch`<N_CH-1, increment `out_ch`. Otherwise, if `continuous`=1 in that cycle, → GATE (latch `resol`, clear counters); else → IDLE.
- Edge counters saturate at all-ones. An edge arriving while saturated sets that channel's ovf bit, which stays set until the next window clears it.
- `start` is ignored while `busy`. `resol` changes outside a window-start cycle have no effect.
- Counts are valid for input frequencies ≤ f_clock/2. Above that, aliasing is accepted and not flagged.
- `out`/`out_ovf` are combinationally muxed from the channel register selected by `out_ch`. They are stable while `out_valid` & !`out_ready`.

## Timing
- Reset (`reset_n`=0 at a clock edge) forces IDLE, from any state including mid-window or mid-drain. Reset values: `busy`=0, `out_valid`=0, `out_ch`=0, `out`=0, `out_ovf`=0; all counters and synchroniser/history flops 0.
- `start` accepted at edge k: `busy`=1 from k+1. GATE occupies cycles k+1 .. k+2^resol. `out_valid`=1 from cycle k+2^resol+1.
- Input-to-count latency is 2 cycles (synchroniser). Edges are attributed to the window by their synchronised time.
- resol=0 gives a 1-cycle window. resol=31 gives a 2^31-cycle window, so the gate counter is 32 bits and must not wrap.
- With `out_ready` held high, DRAIN lasts exactly N_CH cycles. Each stall cycle holds beat contents unchanged.
- Continuous mode: the next GATE starts the cycle after the last accepted beat. Edges during DRAIN are not counted.

## Structure
- Shared package `medidor_pkg`: the state enum (IDLE, GATE, DRAIN) and the constant `GATE_W`=32. Channel width derivation sits alongside for reuse by a future AXI wrapper.
- One natural sub-module: `detector_flanco`, the per-channel synchroniser, history flop and rising-edge pulse, instantiated N_CH times via generate. The FSM, gate counter and result mux live in the top.

## Test plan
- N_CH=4, resol=4, ch0 period 4 cycles, ch1 period 8, ch2 constant 0, ch3 period 2; `out_ready`=1; `start` pulse → beats ch0..3 = 4, 2, 0, 8, all ovf=0, `out_valid` 16 cycles after `start` + 1.
- OUT_WIDTH=4, resol=6, ch0 period 2 → `out`=15, `out_ovf`=1; other channels idle → 0, ovf=0.
- Backpressure: same as first case, `out_ready` low 3 cycles per beat → each beat held unchanged until accepted, `out_ch` increments only on handshake, then IDLE.
- Continuous=1, resol=3, ch0 period 4: three consecutive windows each report 2. Drop `continuous` during the third drain → IDLE after ch3 accepted, no further `out_valid`.
- `reset_n` low mid-GATE and mid-DRAIN → next cycle all outputs 0, `busy`=0. A subsequent `start` gives a correct fresh count.
- resol=0 and `start` during `busy`: 1-cycle window gives count ≤1. A second `start` while busy produces no extra window.
